// File: rtl/aes_block_sequencer_if.sv
// AES core side of the block sequencer: issue handshake, completion and block address.
// Combinational bundle only; no storage or latency of its own.
// aes_req is held until aes_ack; the core signals completion with aes_done.
interface aes_block_sequencer_if #(
   parameter int CNT_W = 32
);
   logic             aes_req;
   logic             aes_ack;
   logic             aes_done;
   logic [31:0]      blk_addr;
   logic [CNT_W-1:0] blk_idx;

   modport master (
      output aes_req,
      output blk_addr,
      output blk_idx,
      input  aes_ack,
      input  aes_done
   );

   modport slave (
      input  aes_req,
      input  blk_addr,
      input  blk_idx,
      output aes_ack,
      output aes_done
   );
endinterface

// File: rtl/aes_block_sequencer.sv
// Walks a multi-block AES job, issuing one request per block at base + idx*BLK_BYTES.
// Latency: 2 cycles per block minimum (ISSUE + WAIT), one extra DONE cycle per job.
// Backpressure: aes_req held until aes_ack; optional watchdog via AES_SEQ_WATCHDOG_EN.
module aes_block_sequencer #(
   parameter int CNT_W     = 32,
   parameter int BLK_BYTES = 16,
   parameter int TIMEOUT   = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CNT_W-1:0]      num_blocks,
   input  logic [31:0]           base_addr,
   input  logic                  abort,
   aes_block_sequencer_if.master aes,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam int SHIFT = $clog2(BLK_BYTES);

   state_t           state_q, state_nxt;
   logic [CNT_W-1:0] idx_q, limit_q;
   logic [31:0]      base_q;
   logic [31:0]      idx_ext;
   logic             aborted_q, err_q;
   logic             job_load, idx_inc, abort_evt, to_evt;
   logic             timeout_hit;
   logic             last_blk;

   // Compare one bit wider so idx+1 can never wrap past the limit.
   assign last_blk = ({1'b0, idx_q} + (CNT_W+1)'(1)) >= {1'b0, limit_q};
   assign idx_ext  = 32'(idx_q);

`ifdef AES_SEQ_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_cnt;

   assign timeout_hit = (wd_cnt == WD_W'(TIMEOUT - 1));

   // Watchdog counts cycles spent in the current ISSUE/WAIT visit; any state change restarts it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         wd_cnt <= '0;
      else if (state_nxt != state_q)
         wd_cnt <= '0;
      else if (state_q == ISSUE || state_q == WAIT)
         wd_cnt <= wd_cnt + 1'b1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT;
   assign timeout_hit    = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= IDLE;
      else
         state_q <= state_nxt;
   end

   // Next-state and control decode; abort outranks timeout, which outranks ack/done.
   always_comb begin
      state_nxt   = state_q;
      job_load    = 1'b0;
      idx_inc     = 1'b0;
      abort_evt   = 1'b0;
      to_evt      = 1'b0;
      aes.aes_req = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               job_load  = 1'b1;
               state_nxt = (num_blocks == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            aes.aes_req = 1'b1;
            if (abort) begin
               abort_evt = 1'b1;
               state_nxt = IDLE;
            end else if (timeout_hit) begin
               to_evt    = 1'b1;
               state_nxt = IDLE;
            end else if (aes.aes_ack) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (abort) begin
               abort_evt = 1'b1;
               state_nxt = IDLE;
            end else if (timeout_hit) begin
               to_evt    = 1'b1;
               state_nxt = IDLE;
            end else if (aes.aes_done) begin
               if (last_blk) begin
                  state_nxt = DONE;
               end else begin
                  idx_inc   = 1'b1;
                  state_nxt = ISSUE;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Job registers, block index and the abort/timeout status flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q     <= '0;
         limit_q   <= '0;
         base_q    <= '0;
         aborted_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         aborted_q <= abort_evt | to_evt;
         if (job_load)
            err_q <= 1'b0;
         else if (to_evt)
            err_q <= 1'b1;
         if (job_load) begin
            limit_q <= num_blocks;
            base_q  <= base_addr;
            idx_q   <= '0;
         end else if (idx_inc) begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign aes.blk_addr = base_q + (idx_ext << SHIFT);
   assign aes.blk_idx  = idx_q;
   assign aborted      = aborted_q;
   assign err          = err_q;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed bench for aes_block_sequencer with hand-computed expectations.
// Inputs driven and outputs sampled on the falling edge; DUT acts on the rising edge.
// Watchdog scenario depends on AES_SEQ_WATCHDOG_EN; otherwise an indefinite stall is checked.
module tb_aes_block_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] num_blocks = '0;
   logic [31:0] base_addr = '0;
   logic        abort = 1'b0;
   logic        busy, done, aborted, err;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int abrt_cnt = 0;
   int req_cnt  = 0;

   aes_block_sequencer_if #(.CNT_W(32)) aes_if ();

   aes_block_sequencer #(.CNT_W(32), .BLK_BYTES(16), .TIMEOUT(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .num_blocks (num_blocks),
      .base_addr  (base_addr),
      .abort      (abort),
      .aes        (aes_if.master),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled at the rising edge, before the state moves on.
   always @(posedge clk) begin
      if (done)           done_cnt <= done_cnt + 1;
      if (aborted)        abrt_cnt <= abrt_cnt + 1;
      if (aes_if.aes_req) req_cnt  <= req_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got running required finished");
      $fatal(1, "bench time limit expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_job(input logic [31:0] n, input logic [31:0] base);
      start      = 1'b1;
      num_blocks = n;
      base_addr  = base;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Entered on a falling edge in ISSUE; leaves on the falling edge after aes_done.
   task automatic do_block(input string tag, input logic [31:0] exp_addr,
                           input logic [31:0] exp_idx, input int ack_dly);
      int held;
      int bad_addr;
      held     = 0;
      bad_addr = 0;
      for (int i = 0; i < ack_dly; i++) begin
         if (aes_if.aes_req) held++;
         if (aes_if.blk_addr !== exp_addr) bad_addr++;
         aes_if.aes_done = 1'b1;
         start      = 1'b1;
         num_blocks = 32'd9;
         base_addr  = 32'hDEAD_0000;
         @(negedge clk);
      end
      aes_if.aes_done = 1'b0;
      start = 1'b0;
      if (aes_if.aes_req) held++;
      if (aes_if.blk_addr !== exp_addr) bad_addr++;
      check({tag, "_addr"}, aes_if.blk_addr, exp_addr);
      check({tag, "_idx"}, aes_if.blk_idx, exp_idx);
      aes_if.aes_ack = 1'b1;
      @(negedge clk);
      aes_if.aes_ack = 1'b0;
      check({tag, "_req_held"}, held, ack_dly + 1);
      check({tag, "_addr_stable_errs"}, bad_addr, 0);
      check({tag, "_req_drop"}, aes_if.aes_req, 1'b0);
      aes_if.aes_done = 1'b1;
      @(negedge clk);
      aes_if.aes_done = 1'b0;
   endtask

   task automatic expect_done(input string tag);
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_busy_in_done"}, busy, 1'b1);
      @(negedge clk);
      check({tag, "_done_clr"}, done, 1'b0);
      check({tag, "_busy_clr"}, busy, 1'b0);
   endtask

   initial begin
      int dc0, ac0, rc0, cyc;
      aes_if.aes_ack  = 1'b0;
      aes_if.aes_done = 1'b0;

      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_aborted", aborted, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_req", aes_if.aes_req, 1'b0);
      check("rst_addr", aes_if.blk_addr, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Three blocks, immediate ack/done.
      dc0 = done_cnt;
      start_job(32'd3, 32'h0000_1000);
      do_block("t1b0", 32'h0000_1000, 32'd0, 0);
      do_block("t1b1", 32'h0000_1010, 32'd1, 0);
      do_block("t1b2", 32'h0000_1020, 32'd2, 0);
      expect_done("t1");
      check("t1_done_pulses", done_cnt - dc0, 1);

      // Zero-block job: straight to DONE, never requests.
      dc0 = done_cnt;
      rc0 = req_cnt;
      start_job(32'd0, 32'h0000_5000);
      check("t2_req", aes_if.aes_req, 1'b0);
      expect_done("t2");
      @(negedge clk);
      check("t2_done_pulses", done_cnt - dc0, 1);
      check("t2_req_cycles", req_cnt - rc0, 0);

      // Delayed ack; start/aes_done noise during ISSUE must be ignored.
      start_job(32'd2, 32'h0000_4000);
      do_block("t3b0", 32'h0000_4000, 32'd0, 5);
      do_block("t3b1", 32'h0000_4010, 32'd1, 0);
      expect_done("t3");

      // Abort during WAIT of block 1, then a clean two-block job.
      dc0 = done_cnt;
      ac0 = abrt_cnt;
      start_job(32'd4, 32'h0000_2000);
      do_block("t4b0", 32'h0000_2000, 32'd0, 0);
      check("t4b1_addr", aes_if.blk_addr, 32'h0000_2010);
      aes_if.aes_ack = 1'b1;
      @(negedge clk);
      aes_if.aes_ack = 1'b0;
      check("t4_in_wait_req", aes_if.aes_req, 1'b0);
      abort = 1'b1;
      aes_if.aes_done = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      aes_if.aes_done = 1'b0;
      check("t4_aborted", aborted, 1'b1);
      check("t4_busy", busy, 1'b0);
      check("t4_done", done, 1'b0);
      @(negedge clk);
      check("t4_aborted_clr", aborted, 1'b0);
      check("t4_done_pulses", done_cnt - dc0, 0);
      check("t4_abort_pulses", abrt_cnt - ac0, 1);
      start_job(32'd2, 32'h0000_3000);
      do_block("t4r0", 32'h0000_3000, 32'd0, 0);
      do_block("t4r1", 32'h0000_3010, 32'd1, 0);
      expect_done("t4r");

      // Address wraps modulo 2^32.
      start_job(32'd2, 32'hFFFF_FFF0);
      do_block("t5b0", 32'hFFFF_FFF0, 32'd0, 0);
      do_block("t5b1", 32'h0000_0000, 32'd1, 0);
      expect_done("t5");

      // Abort and ack on the same edge in ISSUE: abort wins.
      start_job(32'd1, 32'h0000_6000);
      aes_if.aes_ack = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      aes_if.aes_ack = 1'b0;
      abort = 1'b0;
      check("t7_aborted", aborted, 1'b1);
      check("t7_busy", busy, 1'b0);
      check("t7_req", aes_if.aes_req, 1'b0);
      @(negedge clk);

      // Stall in WAIT with aes_done never arriving.
      start_job(32'd1, 32'h0000_7000);
      aes_if.aes_ack = 1'b1;
      @(negedge clk);
      aes_if.aes_ack = 1'b0;
`ifdef AES_SEQ_WATCHDOG_EN
      cyc = 0;
      while (busy && cyc < 20) begin
         cyc++;
         @(negedge clk);
      end
      check("t6_wait_cycles", cyc, 8);
      check("t6_aborted", aborted, 1'b1);
      check("t6_err", err, 1'b1);
      check("t6_done", done, 1'b0);
      @(negedge clk);
      check("t6_err_sticky", err, 1'b1);
      start_job(32'd1, 32'h0000_8000);
      check("t6_err_cleared", err, 1'b0);
      do_block("t6r0", 32'h0000_8000, 32'd0, 0);
      expect_done("t6r");
`else
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) cyc++;
         @(negedge clk);
      end
      check("t6_stall_busy_cycles", cyc, 40);
      check("t6_err", err, 1'b0);
      check("t6_aborted", aborted, 1'b0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t6_abort_after_stall", aborted, 1'b1);
      check("t6_err_after_abort", err, 1'b0);
      @(negedge clk);
`endif

      // Asynchronous reset mid-job.
      dc0 = done_cnt;
      ac0 = abrt_cnt;
      start_job(32'd3, 32'h0000_9000);
      do_block("t8b0", 32'h0000_9000, 32'd0, 0);
      #2;
      reset = 1'b0;
      #1;
      check("t8_busy", busy, 1'b0);
      check("t8_req", aes_if.aes_req, 1'b0);
      check("t8_addr", aes_if.blk_addr, 32'h0);
      check("t8_idx", aes_if.blk_idx, 32'h0);
      check("t8_done", done, 1'b0);
      check("t8_aborted", aborted, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t8_no_pulses", (done_cnt - dc0) + (abrt_cnt - ac0), 0);
      check("t8_idle_busy", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
